// File: rtl/spike_rate_encoder_if.sv
// Stimulus-load channel for the spike rate encoder: one valid/ready handshake
// carrying the three 8-bit channel intensities.
interface spike_rate_encoder_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] i0;
  logic [7:0] i1;
  logic [7:0] i2;

  modport master (
    output in_valid,
    output i0,
    output i1,
    output i2,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  i0,
    input  i1,
    input  i2,
    output in_ready
  );
endinterface

// File: rtl/spike_rate_encoder.sv
// Three-channel deterministic rate encoder: each channel's phase accumulator
// carry becomes a spike, giving floor(i*WINDOW/256) spikes per window.
module spike_rate_encoder #(
  parameter int WINDOW = 64,
  parameter int GAP    = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  spike_rate_encoder_if.slave  in_bus,
  input  logic                 stop,
  output logic                 x0,
  output logic                 x1,
  output logic                 x2,
  output logic                 busy,
  output logic                 done,
  output logic [7:0]           cnt0,
  output logic [7:0]           cnt1,
  output logic [7:0]           cnt2
);

  typedef enum logic [1:0] {S_IDLE, S_ENCODE, S_GAP} state_t;

  localparam logic [7:0] WIN_LAST = 8'(WINDOW);
  localparam logic [7:0] GAP_LAST = (GAP == 0) ? 8'd0 : 8'(GAP - 1);

  state_t     state;
  state_t     next_state;
  logic [7:0] step_cnt;
  logic [7:0] gap_cnt;
  logic [7:0] din [3];
  logic [7:0] lat [3];
  logic [7:0] acc [3];
  logic [7:0] cnt [3];
  logic [8:0] sum [3];
  logic [2:0] spike;
  logic       accept;
  logic       do_step;
  logic       finish;
  logic       abort;

  assign din[0] = in_bus.i0;
  assign din[1] = in_bus.i1;
  assign din[2] = in_bus.i2;

  assign in_bus.in_ready = (state == S_IDLE) && !reset;
  assign busy = (state != S_IDLE);
  assign x0   = spike[0];
  assign x1   = spike[1];
  assign x2   = spike[2];
  assign cnt0 = cnt[0];
  assign cnt1 = cnt[1];
  assign cnt2 = cnt[2];

  always_comb begin
    for (int n = 0; n < 3; n++) begin
      sum[n] = {1'b0, acc[n]} + {1'b0, lat[n]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // stop outranks the end-of-window transition, so an aborted window never pulses done
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    do_step    = 1'b0;
    finish     = 1'b0;
    abort      = 1'b0;
    case (state)
      S_IDLE: begin
        if (in_bus.in_valid) begin
          accept     = 1'b1;
          next_state = S_ENCODE;
        end
      end
      S_ENCODE: begin
        if (stop) begin
          abort      = 1'b1;
          next_state = S_IDLE;
        end else if (step_cnt == WIN_LAST) begin
          finish     = 1'b1;
          next_state = (GAP == 0) ? S_IDLE : S_GAP;
        end else begin
          do_step = 1'b1;
        end
      end
      S_GAP: begin
        if (stop) begin
          abort      = 1'b1;
          next_state = S_IDLE;
        end else if (gap_cnt == GAP_LAST) begin
          next_state = S_IDLE;
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      step_cnt <= 8'd0;
      gap_cnt  <= 8'd0;
      spike    <= 3'b000;
      done     <= 1'b0;
      for (int n = 0; n < 3; n++) begin
        lat[n] <= 8'd0;
        acc[n] <= 8'd0;
        cnt[n] <= 8'd0;
      end
    end else begin
      done <= finish;
      if (accept) begin
        step_cnt <= 8'd0;
        spike    <= 3'b000;
        for (int n = 0; n < 3; n++) begin
          lat[n] <= din[n];
          acc[n] <= 8'd0;
          cnt[n] <= 8'd0;
        end
      end
      // The 9th sum bit is the accumulator overflow, i.e. this step's spike
      if (do_step) begin
        step_cnt <= step_cnt + 8'd1;
        for (int n = 0; n < 3; n++) begin
          spike[n] <= sum[n][8];
          acc[n]   <= sum[n][7:0];
          cnt[n]   <= cnt[n] + {7'd0, sum[n][8]};
        end
      end
      if (finish || abort) begin
        spike <= 3'b000;
      end
      if (finish) begin
        gap_cnt <= 8'd0;
      end else if (state == S_GAP) begin
        gap_cnt <= gap_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_spike_rate_encoder.sv
// Directed bench for spike_rate_encoder: a WINDOW=64/GAP=4 instance for the main
// scenarios and a WINDOW=1/GAP=0 instance for the degenerate corner.
module tb_spike_rate_encoder;

  localparam int WIN = 64;

  logic       clk = 1'b0;
  logic       reset;
  logic       stop;
  logic       x0, x1, x2, busy, done;
  logic [7:0] cnt0, cnt1, cnt2;

  logic       stop_b;
  logic       xb0, xb1, xb2, busy_b, done_b;
  logic [7:0] cntb0, cntb1, cntb2;

  int total = 0;
  int bad   = 0;

  spike_rate_encoder_if bus ();
  spike_rate_encoder_if bus_b ();

  spike_rate_encoder #(.WINDOW(WIN), .GAP(4)) dut (
    .clk(clk), .reset(reset), .in_bus(bus), .stop(stop),
    .x0(x0), .x1(x1), .x2(x2), .busy(busy), .done(done),
    .cnt0(cnt0), .cnt1(cnt1), .cnt2(cnt2)
  );

  spike_rate_encoder #(.WINDOW(1), .GAP(0)) dut_b (
    .clk(clk), .reset(reset), .in_bus(bus_b), .stop(stop_b),
    .x0(xb0), .x1(xb1), .x2(xb2), .busy(busy_b), .done(done_b),
    .cnt0(cntb0), .cnt1(cntb1), .cnt2(cntb2)
  );

  always #5 clk = ~clk;

  // Spike at step k happens when floor(k*i/256) advances
  function automatic logic spike_at(input int k, input int i);
    return ((k * i) / 256) != (((k - 1) * i) / 256);
  endfunction

  task automatic wait_ready;
    int n = 0;
    while (bus.in_ready !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (bus.in_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL wait_ready: in_ready=%b required 1 after %0d cycles", bus.in_ready, n);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({bus.in_ready, busy} !== 2'b00) begin
      bad++;
      $display("[TB] FAIL reset_hold: ready,busy=%b required 00", {bus.in_ready, busy});
    end
    reset = 1'b0;
    @(negedge clk);
    total++;
    if ({bus.in_ready, busy, done, x2, x1, x0, cnt2, cnt1, cnt0} !== {6'b100000, 24'd0}) begin
      bad++;
      $display("[TB] FAIL reset_state: ready,busy,done,x=%b cnt=%0d/%0d/%0d required 100000 0/0/0",
               {bus.in_ready, busy, done, x2, x1, x0}, cnt0, cnt1, cnt2);
    end
  endtask

  task automatic test_window(input int a, input int b, input int c, input string tag);
    logic [2:0]  ex;
    logic [23:0] ecnt;
    ecnt = {8'((c * WIN) / 256), 8'((b * WIN) / 256), 8'((a * WIN) / 256)};
    wait_ready();
    bus.i0 = 8'(a); bus.i1 = 8'(b); bus.i2 = 8'(c);
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    total++;
    if ({busy, bus.in_ready, x2, x1, x0} !== 5'b10000) begin
      bad++;
      $display("[TB] FAIL %s accept: busy,ready,x=%b required 10000", tag, {busy, bus.in_ready, x2, x1, x0});
    end
    for (int k = 1; k <= WIN; k++) begin
      @(negedge clk);
      if (k == 30) begin
        bus.in_valid = 1'b1;
        bus.i0 = ~8'(a); bus.i1 = ~8'(b); bus.i2 = 8'd255;
      end
      if (k == 33) bus.in_valid = 1'b0;
      ex = {spike_at(k, c), spike_at(k, b), spike_at(k, a)};
      total++;
      if ({done, x2, x1, x0} !== {1'b0, ex}) begin
        bad++;
        $display("[TB] FAIL %s step %0d: done,x=%b required 0%b", tag, k, {done, x2, x1, x0}, ex);
      end
    end
    @(negedge clk);
    total++;
    if ({done, busy, bus.in_ready, x2, x1, x0} !== 6'b110000) begin
      bad++;
      $display("[TB] FAIL %s done_pulse: done,busy,ready,x=%b required 110000", tag,
               {done, busy, bus.in_ready, x2, x1, x0});
    end
    total++;
    if ({cnt2, cnt1, cnt0} !== ecnt) begin
      bad++;
      $display("[TB] FAIL %s counts: cnt=%0d/%0d/%0d required %0d/%0d/%0d", tag,
               cnt0, cnt1, cnt2, ecnt[7:0], ecnt[15:8], ecnt[23:16]);
    end
    for (int g = 2; g <= 4; g++) begin
      @(negedge clk);
      total++;
      if ({done, busy, bus.in_ready, x2, x1, x0} !== 6'b010000) begin
        bad++;
        $display("[TB] FAIL %s gap %0d: done,busy,ready,x=%b required 010000", tag, g,
                 {done, busy, bus.in_ready, x2, x1, x0});
      end
    end
    @(negedge clk);
    total++;
    if ({busy, bus.in_ready, cnt2, cnt1, cnt0} !== {2'b01, ecnt}) begin
      bad++;
      $display("[TB] FAIL %s idle_after_gap: busy,ready=%b cnt0=%0d required 01 cnt0=%0d", tag,
               {busy, bus.in_ready}, cnt0, ecnt[7:0]);
    end
  endtask

  task automatic test_back_to_back;
    int not_ready = 0;
    wait_ready();
    bus.i0 = 8'd128; bus.i1 = 8'd64; bus.i2 = 8'd0;
    bus.in_valid = 1'b1;
    @(negedge clk);
    while (bus.in_ready !== 1'b1 && not_ready < 200) begin
      not_ready++;
      if (not_ready >= 66) begin
        total++;
        if ({busy, x2, x1, x0} !== 4'b1000) begin
          bad++;
          $display("[TB] FAIL b2b_gap cycle %0d: busy,x=%b required 1000", not_ready, {busy, x2, x1, x0});
        end
      end
      @(negedge clk);
    end
    total++;
    if (not_ready !== 69) begin
      bad++;
      $display("[TB] FAIL b2b_ready_low: low cycles=%0d required 69", not_ready);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    total++;
    if ({busy, bus.in_ready, cnt0} !== {2'b10, 8'd0}) begin
      bad++;
      $display("[TB] FAIL b2b_second_accept: busy,ready=%b cnt0=%0d required 10 cnt0=0",
               {busy, bus.in_ready}, cnt0);
    end
    wait_ready();
  endtask

  task automatic test_stop;
    wait_ready();
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    total++;
    if ({busy, bus.in_ready} !== 2'b01) begin
      bad++;
      $display("[TB] FAIL stop_idle: busy,ready=%b required 01", {busy, bus.in_ready});
    end
    bus.i0 = 8'd128; bus.i1 = 8'd0; bus.i2 = 8'd0;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (10) @(negedge clk);
    total++;
    if ({x0, cnt0} !== {1'b1, 8'd5}) begin
      bad++;
      $display("[TB] FAIL stop_step10: x0=%b cnt0=%0d required 1 cnt0=5", x0, cnt0);
    end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    total++;
    if ({busy, bus.in_ready, done, x2, x1, x0, cnt0} !== {6'b010000, 8'd5}) begin
      bad++;
      $display("[TB] FAIL stop_abort: busy,ready,done,x=%b cnt0=%0d required 010000 cnt0=5",
               {busy, bus.in_ready, done, x2, x1, x0}, cnt0);
    end
    @(negedge clk);
    total++;
    if ({done, busy, cnt0} !== {2'b00, 8'd5}) begin
      bad++;
      $display("[TB] FAIL stop_after: done,busy=%b cnt0=%0d required 00 cnt0=5", {done, busy}, cnt0);
    end
  endtask

  task automatic test_reset_midwindow;
    wait_ready();
    bus.i0 = 8'd128; bus.i1 = 8'd64; bus.i2 = 8'd0;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (20) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    total++;
    if ({busy, bus.in_ready, done, x2, x1, x0, cnt2, cnt1, cnt0} !== {6'b000000, 24'd0}) begin
      bad++;
      $display("[TB] FAIL reset_mid: busy,ready,done,x=%b cnt=%0d/%0d/%0d required 000000 0/0/0",
               {busy, bus.in_ready, done, x2, x1, x0}, cnt0, cnt1, cnt2);
    end
    reset = 1'b0;
    @(negedge clk);
    total++;
    if ({busy, bus.in_ready} !== 2'b01) begin
      bad++;
      $display("[TB] FAIL reset_release: busy,ready=%b required 01", {busy, bus.in_ready});
    end
    test_window(128, 64, 0, "after_reset");
  endtask

  task automatic test_short_window;
    total++;
    if (bus_b.in_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL short_ready: in_ready=%b required 1", bus_b.in_ready);
    end
    bus_b.i0 = 8'd255; bus_b.i1 = 8'd255; bus_b.i2 = 8'd128;
    bus_b.in_valid = 1'b1;
    @(negedge clk);
    bus_b.in_valid = 1'b0;
    total++;
    if ({busy_b, bus_b.in_ready} !== 2'b10) begin
      bad++;
      $display("[TB] FAIL short_accept: busy,ready=%b required 10", {busy_b, bus_b.in_ready});
    end
    @(negedge clk);
    total++;
    if ({done_b, xb2, xb1, xb0} !== 4'b0000) begin
      bad++;
      $display("[TB] FAIL short_step1: done,x=%b required 0000", {done_b, xb2, xb1, xb0});
    end
    @(negedge clk);
    total++;
    if ({done_b, busy_b, bus_b.in_ready, xb0, cntb2, cntb1, cntb0} !== {4'b1010, 24'd0}) begin
      bad++;
      $display("[TB] FAIL short_done: done,busy,ready,x0=%b cnt=%0d/%0d/%0d required 1010 0/0/0",
               {done_b, busy_b, bus_b.in_ready, xb0}, cntb0, cntb1, cntb2);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset = 1'b1;
    stop = 1'b0;
    stop_b = 1'b0;
    bus.in_valid = 1'b0;
    bus.i0 = 8'd0; bus.i1 = 8'd0; bus.i2 = 8'd0;
    bus_b.in_valid = 1'b0;
    bus_b.i0 = 8'd0; bus_b.i1 = 8'd0; bus_b.i2 = 8'd0;
    @(negedge clk);
    test_reset();
    test_window(128, 64, 0, "basic");
    test_window(255, 1, 200, "high");
    test_back_to_back();
    test_stop();
    test_reset_midwindow();
    test_short_window();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
